// File: rtl/fir_package.sv
// rtl/fir_package.sv - shared constants and response record for the TCDM responder
package fir_package;

  localparam int FIR_TCDM_RESP_DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
  } fir_tcdm_resp_t;

endpackage

// File: rtl/fir_tcdm_responder_if.sv
// rtl/fir_tcdm_responder_if.sv - TCDM request/response bundle between initiator and responder
interface fir_tcdm_responder_if #(
  parameter int MEM_WIDTH = 32
);
  logic                   req_i;
  logic                   gnt_o;
  logic [31:0]            add_i;
  logic                   wen_i;
  logic [MEM_WIDTH/8-1:0] be_i;
  logic [MEM_WIDTH-1:0]   data_i;
  logic [MEM_WIDTH-1:0]   r_data_o;
  logic                   r_valid_o;
  logic                   r_ready_i;

  modport master (
    output req_i, add_i, wen_i, be_i, data_i, r_ready_i,
    input  gnt_o, r_data_o, r_valid_o
  );

  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i, r_ready_i,
    output gnt_o, r_data_o, r_valid_o
  );
endinterface

// File: rtl/fir_tcdm_resp_queue.sv
// rtl/fir_tcdm_resp_queue.sv - synchronous response FIFO with push, pop, full, empty and clear
module fir_tcdm_resp_queue
  import fir_package::*;
#(
  parameter int DEPTH = FIR_TCDM_RESP_DEPTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           push_i,
  input  fir_tcdm_resp_t push_data_i,
  input  logic           pop_i,
  output fir_tcdm_resp_t pop_data_o,
  output logic           full_o,
  output logic           empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fir_tcdm_resp_t slot_q [DEPTH];
  fir_tcdm_resp_t slot_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = slot_q[rd_ptr_q];

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slot_d[wr_ptr_q] = push_data_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    slot_q <= slot_d;
  end
endmodule

// File: rtl/fir_tcdm_responder.sv
// rtl/fir_tcdm_responder.sv - TCDM memory responder with in-order response queue and access counters
module fir_tcdm_responder
  import fir_package::*;
#(
  parameter int MEM_WIDTH  = 32,
  parameter int NB_WORDS   = 1024,
  parameter int RESP_DEPTH = FIR_TCDM_RESP_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        stall_i,
  fir_tcdm_responder_if.slave         tcdm,
  output logic [15:0]                 nb_rd_o,
  output logic [15:0]                 nb_wr_o
);
  localparam int AW = $clog2(NB_WORDS);

  logic [MEM_WIDTH-1:0] mem_q [NB_WORDS];
  logic [AW-1:0]        idx;
  logic                 gnt, pop, full, empty;
  fir_tcdm_resp_t       push_data, head;
  logic [15:0]          nb_rd_q, nb_rd_d;
  logic [15:0]          nb_wr_q, nb_wr_d;
  logic                 unused_addr_bits;

  // Only the word index bits matter; the rest of the byte address aliases.
  assign idx              = tcdm.add_i[AW+1:2];
  assign unused_addr_bits = ^{tcdm.add_i[31:AW+2], tcdm.add_i[1:0]};

  assign pop = ~empty & tcdm.r_ready_i;
  assign gnt = tcdm.req_i & ~stall_i & ~rst_i & ~clear_i & (~full | pop);

  assign tcdm.gnt_o     = gnt;
  assign tcdm.r_valid_o = ~empty;
  assign tcdm.r_data_o  = empty ? '0 : head.data;

  always_comb begin
    push_data      = '0;
    push_data.data = tcdm.wen_i ? mem_q[idx] : '0;
  end

  always_comb begin
    nb_rd_d = nb_rd_q;
    nb_wr_d = nb_wr_q;
    if (gnt && tcdm.wen_i && nb_rd_q != 16'hFFFF) nb_rd_d = nb_rd_q + 16'd1;
    if (gnt && !tcdm.wen_i && nb_wr_q != 16'hFFFF) nb_wr_d = nb_wr_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nb_rd_q <= '0;
      nb_wr_q <= '0;
    end else begin
      nb_rd_q <= nb_rd_d;
      nb_wr_q <= nb_wr_d;
    end
  end

  // Array is deliberately outside reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (gnt && !tcdm.wen_i) begin
      for (int b = 0; b < MEM_WIDTH / 8; b++) begin
        if (tcdm.be_i[b]) mem_q[idx][8*b +: 8] <= tcdm.data_i[8*b +: 8];
      end
    end
  end

  assign nb_rd_o = nb_rd_q;
  assign nb_wr_o = nb_wr_q;

  fir_tcdm_resp_queue #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .push_i     (gnt),
    .push_data_i(push_data),
    .pop_i      (pop),
    .pop_data_o (head),
    .full_o     (full),
    .empty_o    (empty)
  );
endmodule
